// File: rtl/bus_control_logic_if.sv
// rtl/bus_control_logic_if.sv - CPU-side pin bundle of the 8259A bus front end
interface bus_control_logic_if;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       read_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       ICW_1;
  logic       ICW_2_4;
  logic       OCW_1;
  logic       OCW_2;
  logic       OCW_3;
  logic       read;
  logic       init_busy;

  modport master (
    output chip_select_n, write_enable_n, read_enable_n, address, data_bus_in,
    input  internal_data_bus, ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, read, init_busy
  );

  modport slave (
    input  chip_select_n, write_enable_n, read_enable_n, address, data_bus_in,
    output internal_data_bus, ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, read, init_busy
  );
endinterface

// File: rtl/bus_control_logic.sv
// rtl/bus_control_logic.sv - 8259A write decode and ICW sequencer; BUS_CTRL_SYNC_EN adds pin synchronizers
module bus_control_logic (
  input  logic               clk,
  input  logic               reset_n,
  bus_control_logic_if.slave bus
);

  typedef enum logic [1:0] {SEQ_READY, SEQ_ICW2, SEQ_ICW3, SEQ_ICW4} seq_state_t;

  logic       cs_n_in, wr_n_in, rd_n_in, a0_in;
  logic [7:0] data_in;

`ifdef BUS_CTRL_SYNC_EN
  logic [1:0] cs_sync_q, cs_sync_d, wr_sync_q, wr_sync_d;
  logic [1:0] rd_sync_q, rd_sync_d, a0_sync_q, a0_sync_d;
  logic [7:0] data_dly0_q, data_dly0_d, data_dly1_q, data_dly1_d;

  always_comb begin
    cs_sync_d   = {cs_sync_q[0], bus.chip_select_n};
    wr_sync_d   = {wr_sync_q[0], bus.write_enable_n};
    rd_sync_d   = {rd_sync_q[0], bus.read_enable_n};
    a0_sync_d   = {a0_sync_q[0], bus.address};
    data_dly0_d = bus.data_bus_in;
    data_dly1_d = data_dly0_q;
  end

  // Strobes reset to their inactive (high) level; data is only delayed to stay aligned with wr_act.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= 2'b11;
      wr_sync_q   <= 2'b11;
      rd_sync_q   <= 2'b11;
      a0_sync_q   <= 2'b00;
      data_dly0_q <= 8'h00;
      data_dly1_q <= 8'h00;
    end else begin
      cs_sync_q   <= cs_sync_d;
      wr_sync_q   <= wr_sync_d;
      rd_sync_q   <= rd_sync_d;
      a0_sync_q   <= a0_sync_d;
      data_dly0_q <= data_dly0_d;
      data_dly1_q <= data_dly1_d;
    end
  end

  assign cs_n_in = cs_sync_q[1];
  assign wr_n_in = wr_sync_q[1];
  assign rd_n_in = rd_sync_q[1];
  assign a0_in   = a0_sync_q[1];
  assign data_in = data_dly1_q;
`else
  assign cs_n_in = bus.chip_select_n;
  assign wr_n_in = bus.write_enable_n;
  assign rd_n_in = bus.read_enable_n;
  assign a0_in   = bus.address;
  assign data_in = bus.data_bus_in;
`endif

  logic       wr_act_q, wr_act_d, wr_prev_q, wr_prev_d;
  logic       read_q, read_d;
  logic       a0_s1_q, a0_s1_d, hold_a0_q, hold_a0_d;
  logic [7:0] data_s1_q, data_s1_d, hold_data_q, hold_data_d;
  logic       icw_1_q, icw_1_d, icw_2_4_q, icw_2_4_d;
  logic       ocw_1_q, ocw_1_d, ocw_2_q, ocw_2_d, ocw_3_q, ocw_3_d;
  logic [7:0] bus_q, bus_d;
  logic       sngl_q, sngl_d, ic4_q, ic4_d;
  seq_state_t state_q, state_d;
  logic       complete;

  always_comb begin
    wr_act_d    = ~cs_n_in & ~wr_n_in;
    // A concurrent write masks the read level.
    read_d      = ~cs_n_in & ~rd_n_in & ~wr_act_d;
    wr_prev_d   = wr_act_q;
    a0_s1_d     = a0_in;
    data_s1_d   = data_in;
    hold_a0_d   = wr_act_q ? a0_s1_q   : hold_a0_q;
    hold_data_d = wr_act_q ? data_s1_q : hold_data_q;
    complete    = wr_prev_q & ~wr_act_q;

    icw_1_d   = 1'b0;
    icw_2_4_d = 1'b0;
    ocw_1_d   = 1'b0;
    ocw_2_d   = 1'b0;
    ocw_3_d   = 1'b0;
    bus_d     = bus_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    state_d   = state_q;

    if (complete) begin
      bus_d = hold_data_q;
      if (!hold_a0_q) begin
        if (hold_data_q[4]) begin
          icw_1_d = 1'b1;
          sngl_d  = hold_data_q[1];
          ic4_d   = hold_data_q[0];
          state_d = SEQ_ICW2;
        end else if (hold_data_q[3]) begin
          ocw_3_d = 1'b1;
        end else begin
          ocw_2_d = 1'b1;
        end
      end else if (state_q == SEQ_READY) begin
        ocw_1_d = 1'b1;
      end else begin
        icw_2_4_d = 1'b1;
        case (state_q)
          SEQ_ICW2: state_d = !sngl_q ? SEQ_ICW3 : (ic4_q ? SEQ_ICW4 : SEQ_READY);
          SEQ_ICW3: state_d = ic4_q ? SEQ_ICW4 : SEQ_READY;
          default:  state_d = SEQ_READY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_act_q    <= 1'b0;
      wr_prev_q   <= 1'b0;
      read_q      <= 1'b0;
      a0_s1_q     <= 1'b0;
      data_s1_q   <= 8'h00;
      hold_a0_q   <= 1'b0;
      hold_data_q <= 8'h00;
      icw_1_q     <= 1'b0;
      icw_2_4_q   <= 1'b0;
      ocw_1_q     <= 1'b0;
      ocw_2_q     <= 1'b0;
      ocw_3_q     <= 1'b0;
      bus_q       <= 8'h00;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      state_q     <= SEQ_READY;
    end else begin
      wr_act_q    <= wr_act_d;
      wr_prev_q   <= wr_prev_d;
      read_q      <= read_d;
      a0_s1_q     <= a0_s1_d;
      data_s1_q   <= data_s1_d;
      hold_a0_q   <= hold_a0_d;
      hold_data_q <= hold_data_d;
      icw_1_q     <= icw_1_d;
      icw_2_4_q   <= icw_2_4_d;
      ocw_1_q     <= ocw_1_d;
      ocw_2_q     <= ocw_2_d;
      ocw_3_q     <= ocw_3_d;
      bus_q       <= bus_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      state_q     <= state_d;
    end
  end

  assign bus.internal_data_bus = bus_q;
  assign bus.ICW_1             = icw_1_q;
  assign bus.ICW_2_4           = icw_2_4_q;
  assign bus.OCW_1             = ocw_1_q;
  assign bus.OCW_2             = ocw_2_q;
  assign bus.OCW_3             = ocw_3_q;
  assign bus.read              = read_q;
  assign bus.init_busy         = (state_q != SEQ_READY);

endmodule

// File: tb/tb_bus_control_logic.sv
// tb/tb_bus_control_logic.sv - table-driven scoreboard bench for bus_control_logic
module tb_bus_control_logic;
  logic clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;

  bus_control_logic_if bif ();

  bus_control_logic dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  typedef struct {
    logic       a0;
    logic [7:0] d;
    logic [4:0] stb;
    logic [7:0] bus;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [4:0] stb;
    logic [7:0] bus;
    logic       busy;
    int         due;
  } exp_t;

  // Strobe vector order: {ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3}
  localparam logic [4:0] S_ICW1 = 5'b10000;
  localparam logic [4:0] S_ICW24 = 5'b01000;
  localparam logic [4:0] S_OCW1 = 5'b00100;
  localparam logic [4:0] S_OCW2 = 5'b00010;
  localparam logic [4:0] S_OCW3 = 5'b00001;

  vec_t vecs[17];
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] stb_now;
  assign stb_now = {bif.ICW_1, bif.ICW_2_4, bif.OCW_1, bif.OCW_2, bif.OCW_3};

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (stb_now !== e.stb || bif.internal_data_bus !== e.bus || bif.init_busy !== e.busy) begin
        bad++;
        $display("FAIL write_result cyc=%0d: got stb=%b bus=%h busy=%b, want stb=%b bus=%h busy=%b",
                 cyc, stb_now, bif.internal_data_bus, bif.init_busy, e.stb, e.bus, e.busy);
      end
    end else begin
      total++;
      if (stb_now !== 5'b0) begin
        bad++;
        $display("FAIL idle_strobe cyc=%0d: got stb=%b, want 00000", cyc, stb_now);
      end
    end
  end

  task automatic do_write(input logic a, input logic [7:0] d, input logic [4:0] stb,
                          input logic [7:0] ebus, input logic busy);
    exp_t e;
    @(posedge clk);
    #1;
    bif.chip_select_n  = 1'b0;
    bif.write_enable_n = 1'b0;
    bif.address        = a;
    bif.data_bus_in    = d;
    @(posedge clk);
    #1;
    bif.chip_select_n  = 1'b1;
    bif.write_enable_n = 1'b1;
    e.stb  = stb;
    e.bus  = ebus;
    e.busy = busy;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_read(input string name, input logic want);
    total++;
    if (bif.read !== want) begin
      bad++;
      $display("FAIL %s: got read=%b, want %b", name, bif.read, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({bif.internal_data_bus, stb_now, bif.read, bif.init_busy} !== 15'h0) begin
      bad++;
      $display("FAIL %s: got bus=%h stb=%b read=%b busy=%b, want all 0",
               name, bif.internal_data_bus, stb_now, bif.read, bif.init_busy);
    end
  endtask

  initial begin
    cyc = 0;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    bif.chip_select_n  = 1'b1;
    bif.write_enable_n = 1'b1;
    bif.read_enable_n  = 1'b1;
    bif.address        = 1'b0;
    bif.data_bus_in    = 8'h00;

    vecs[0]  = '{1'b0, 8'h0A, S_OCW3,  8'h0A, 1'b0};
    vecs[1]  = '{1'b0, 8'h1B, S_ICW1,  8'h1B, 1'b1};
    vecs[2]  = '{1'b1, 8'h20, S_ICW24, 8'h20, 1'b1};
    vecs[3]  = '{1'b1, 8'h03, S_ICW24, 8'h03, 1'b0};
    vecs[4]  = '{1'b0, 8'h10, S_ICW1,  8'h10, 1'b1};
    vecs[5]  = '{1'b1, 8'h08, S_ICW24, 8'h08, 1'b1};
    vecs[6]  = '{1'b1, 8'h04, S_ICW24, 8'h04, 1'b0};
    vecs[7]  = '{1'b1, 8'hFF, S_OCW1,  8'hFF, 1'b0};
    vecs[8]  = '{1'b0, 8'h20, S_OCW2,  8'h20, 1'b0};
    vecs[9]  = '{1'b0, 8'h0A, S_OCW3,  8'h0A, 1'b0};
    vecs[10] = '{1'b1, 8'h55, S_OCW1,  8'h55, 1'b0};
    vecs[11] = '{1'b0, 8'h10, S_ICW1,  8'h10, 1'b1};
    vecs[12] = '{1'b1, 8'h08, S_ICW24, 8'h08, 1'b1};
    vecs[13] = '{1'b0, 8'h13, S_ICW1,  8'h13, 1'b1};
    vecs[14] = '{1'b1, 8'hAA, S_ICW24, 8'hAA, 1'b1};
    vecs[15] = '{1'b0, 8'h20, S_OCW2,  8'h20, 1'b1};
    vecs[16] = '{1'b1, 8'h01, S_ICW24, 8'h01, 1'b0};

    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back writes with the minimum single inactive cycle between them.
    for (int i = 0; i < 17; i++) begin
      do_write(vecs[i].a0, vecs[i].d, vecs[i].stb, vecs[i].bus, vecs[i].busy);
    end
    drain("table");

    @(posedge clk);
    #1;
    bif.chip_select_n = 1'b0;
    bif.read_enable_n = 1'b0;
    @(negedge clk);
    check_read("read_latency", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (i == 2) begin
        #1;
        bif.chip_select_n = 1'b1;
        bif.read_enable_n = 1'b1;
      end
      @(negedge clk);
      check_read("read_level", 1'b1);
    end
    @(negedge clk);
    check_read("read_release", 1'b0);

    @(posedge clk);
    #1;
    bif.chip_select_n = 1'b0;
    bif.read_enable_n = 1'b0;
    bif.address       = 1'b1;
    bif.data_bus_in   = 8'h77;
    @(posedge clk);
    #1;
    bif.write_enable_n = 1'b0;
    @(negedge clk);
    check_read("overlap_before", 1'b1);
    @(posedge clk);
    #1;
    bif.write_enable_n = 1'b1;
    begin
      exp_t e;
      e.stb = S_OCW1;
      e.bus = 8'h77;
      e.busy = 1'b0;
      e.due = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    check_read("overlap_masked", 1'b0);
    @(negedge clk);
    check_read("overlap_after", 1'b1);
    @(posedge clk);
    #1;
    bif.chip_select_n = 1'b1;
    bif.read_enable_n = 1'b1;
    drain("overlap");

    do_write(1'b0, 8'h11, S_ICW1, 8'h11, 1'b1);
    drain("pre_reset");
    @(posedge clk);
    #1;
    bif.chip_select_n  = 1'b0;
    bif.write_enable_n = 1'b0;
    bif.address        = 1'b0;
    bif.data_bus_in    = 8'h1C;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    bif.chip_select_n  = 1'b1;
    bif.write_enable_n = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset_mid_write");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
